// File: rtl/spi_pkg.sv
// Shared SPI link definitions used by the slave (and the matching master).
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // System clock must run at least this many times faster than sclk.
  localparam int MIN_OVERSAMPLE = 8;

  // Frame width shared with spi_master instances on the same link.
  localparam int SPI_WIDTH = 13;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, followed by a history flop
// that produces registered single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              rise_q;
  logic              fall_q;

  // NOTE: non-blocking assignments let every flop in the chain sample its
  // predecessor's old value, which is what makes this a shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      hist_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[STAGES-1] & hist_q;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave (mode 0, MSB first) oversampled by clk, with one-word TX buffer.
// Optional SPI_SLAVE_MISO_OE_EN adds miso_oe and tristates miso outside a frame.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             load,
  input  logic             mosi,
  output logic             miso,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic             miso_oe,
`endif
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_we,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_FULL = cnt_t'(WIDTH);
  localparam cnt_t CNT_MAX  = cnt_t'(WIDTH + 1);

  logic sclk_rise, sclk_fall, load_rise, load_fall, mosi_s;
  logic sclk_s_unused, load_s_unused, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din_i(sclk),
    .sync_o(sclk_s_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // load idles high, so its synchronizer resets high to avoid a false frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
    .clk(clk), .rst(rst), .din_i(load),
    .sync_o(load_s_unused), .rise_o(load_rise), .fall_o(load_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din_i(mosi),
    .sync_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  cnt_t             bit_cnt_q, bit_cnt_d;
  logic             tx_ready_q, tx_ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             underrun_q, underrun_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_buf_q    <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      tx_ready_q  <= 1'b1;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_buf_q    <= tx_buf_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
    end
  end

  // NOTE: every _d gets a default before any branch so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    tx_buf_d    = tx_buf_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    tx_ready_d  = tx_ready_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    underrun_d  = 1'b0;

    if (tx_we && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (load_fall) begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
          if (!tx_ready_q) begin
            tx_sr_d    = tx_buf_q;
            tx_ready_d = 1'b1;
          end else begin
            tx_sr_d    = '0;
            underrun_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_s};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + cnt_t'(1);
        end
        // Count check uses the post-sample count so a coincident rise is included.
        if (load_rise) begin
          if (bit_cnt_d == CNT_FULL) begin
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sclk_fall) begin
          tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_MISO_OE_EN
  assign miso_oe = (state_q == SHIFT);
  assign miso    = miso_oe ? tx_sr_q[WIDTH-1] : 1'bz;
`else
  assign miso    = tx_sr_q[WIDTH-1];
`endif

  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign tx_underrun = underrun_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a pin-level SPI master model drives frames and
// pulse monitors count rx_valid / frame_err / tx_underrun.
module tb_spi_slave;

  localparam int W    = 13;
  localparam int S    = 2;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst, sclk, load, mosi, tx_we;
  logic [W-1:0] tx_data;
  wire          miso;
`ifdef SPI_SLAVE_MISO_OE_EN
  wire          miso_oe;
`endif
  logic         tx_ready, rx_valid, frame_err, tx_underrun, busy;
  logic [W-1:0] rx_data;

  spi_slave #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .load(load), .mosi(mosi), .miso(miso),
`ifdef SPI_SLAVE_MISO_OE_EN
    .miso_oe(miso_oe),
`endif
    .tx_data(tx_data), .tx_we(tx_we), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_valid = 0, n_err = 0, n_unr = 0;

  always @(posedge clk) begin
    if (rx_valid === 1'b1)    n_valid++;
    if (frame_err === 1'b1)   n_err++;
    if (tx_underrun === 1'b1) n_unr++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [W-1:0] v);
    tx_data = v;
    tx_we   = 1'b1;
    tick(1);
    tx_we   = 1'b0;
  endtask

  // Master model: mosi set before each sclk rise, miso captured at the rise.
  task automatic frame(input logic [63:0] din, input int nbits, input logic we_at_fall,
                       input logic [W-1:0] we_val, output logic [63:0] dout, output int lat);
    dout = '0;
    lat  = 0;
    load = 1'b0;
    mosi = din[nbits-1];
    if (we_at_fall) begin
      tick(S + 1);
      tx_data = we_val;
      tx_we   = 1'b1;
      tick(1);
      tx_we   = 1'b0;
      tick(HALF - S - 2);
    end else begin
      tick(HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      dout = {dout[62:0], miso};
      tick(HALF);
      sclk = 1'b0;
      if (i + 1 < nbits) mosi = din[nbits-2-i];
      tick(HALF);
    end
    load = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (rx_valid === 1'b1 && lat == 0) lat = k;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] dout;
    int          lat;
    int          v0, e0, u0;

    rst = 1'b1; sclk = 1'b0; load = 1'b1; mosi = 1'b0;
    tx_we = 1'b0; tx_data = '0;
    tick(3);
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_tx_underrun", tx_underrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    // Loopback
    write(13'h1A5B);
    check("lb_tx_ready_full", tx_ready, 0);
    v0 = n_valid; u0 = n_unr;
    frame(64'h0F0F, W, 1'b0, '0, dout, lat);
    check("lb_rx_data", rx_data, 13'h0F0F);
    check("lb_master_rx", dout[W-1:0], 13'h1A5B);
    check("lb_valid_count", n_valid - v0, 1);
    check("lb_valid_latency", lat, S + 2);
    check("lb_tx_ready_back", tx_ready, 1);
    check("lb_no_underrun", n_unr - u0, 0);
    check("lb_busy_idle", busy, 0);

    // Underrun
    u0 = n_unr;
    frame(64'h0123, W, 1'b0, '0, dout, lat);
    check("unr_pulse", n_unr - u0, 1);
    check("unr_master_rx", dout[W-1:0], 0);
    check("unr_rx_data", rx_data, 13'h0123);

    // Short frame
    v0 = n_valid; e0 = n_err;
    frame(64'h7F, 7, 1'b0, '0, dout, lat);
    check("short_err", n_err - e0, 1);
    check("short_no_valid", n_valid - v0, 0);
    check("short_rx_hold", rx_data, 13'h0123);

    // Long frame, then a normal one
    e0 = n_err;
    frame(64'h7FFF, 15, 1'b0, '0, dout, lat);
    check("long_err", n_err - e0, 1);
    check("long_rx_hold", rx_data, 13'h0123);
    v0 = n_valid;
    frame(64'h1555, W, 1'b0, '0, dout, lat);
    check("after_long_rx", rx_data, 13'h1555);
    check("after_long_valid", n_valid - v0, 1);

    // Second write while full is dropped
    write(13'h0001);
    write(13'h0002);
    check("buf_full", tx_ready, 0);
    frame(64'h0AAA, W, 1'b0, '0, dout, lat);
    check("buf_first_wins", dout[W-1:0], 13'h0001);
    check("buf_empty_after", tx_ready, 1);
    frame(64'h0AAA, W, 1'b0, '0, dout, lat);
    check("buf_second_dropped", dout[W-1:0], 13'h0000);

    // Write coinciding with load_fall on empty buffer
    u0 = n_unr;
    frame(64'h0333, W, 1'b1, 13'h0ABC, dout, lat);
    check("same_cycle_underrun", n_unr - u0, 1);
    check("same_cycle_master_rx", dout[W-1:0], 0);
    check("same_cycle_stored", tx_ready, 0);
    frame(64'h0444, W, 1'b0, '0, dout, lat);
    check("same_cycle_next_tx", dout[W-1:0], 13'h0ABC);
    check("same_cycle_next_rx", rx_data, 13'h0444);

    // Reset mid-frame
    write(13'h1FFF);
    load = 1'b0;
    mosi = 1'b1;
    tick(HALF);
    repeat (6) begin
      sclk = 1'b1; tick(HALF);
      sclk = 1'b0; tick(HALF);
    end
    check("mid_busy", busy, 1);
    check("mid_miso", miso, 1);
    v0 = n_valid; e0 = n_err; u0 = n_unr;
    rst  = 1'b1;
    load = 1'b1;
    tick(2);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    tick(10);
    check("mid_rst_no_valid", n_valid - v0, 0);
    check("mid_rst_no_err", n_err - e0, 0);
    check("mid_rst_no_unr", n_unr - u0, 0);
    write(13'h1234);
    frame(64'h0765, W, 1'b0, '0, dout, lat);
    check("post_rst_rx", rx_data, 13'h0765);
    check("post_rst_master_rx", dout[W-1:0], 13'h1234);
    check("post_rst_latency", lat, S + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
